// File: rtl/rom_nibble_responder_pkg.sv
// Shared constants and phase encoding for the nibble-bus program-memory responder.
// The phase values are those of the CPU's fetch-cycle phases.
package rom_nibble_responder_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        A1   = 4'd1,
        A2   = 4'd2,
        A3   = 4'd3,
        M1   = 4'd4,
        M2   = 4'd5,
        X1   = 4'd6,
        X2   = 4'd7,
        X3   = 4'd8
    } phase_t;

endpackage

// File: rtl/rom_nibble_responder_if.sv
// Multiplexed 4-bit instruction bus as seen between the CPU (master) and
// the program memory (slave).
interface rom_nibble_responder_if;
    import rom_nibble_responder_pkg::*;

    logic                sync_n;
    logic [NIBBLE_W-1:0] data_bus_in;
    logic [NIBBLE_W-1:0] data_bus_out;
    logic                data_bus_oe;
    logic                selected;

    modport master (
        output sync_n,
        output data_bus_in,
        input  data_bus_out,
        input  data_bus_oe,
        input  selected
    );

    modport slave (
        input  sync_n,
        input  data_bus_in,
        output data_bus_out,
        output data_bus_oe,
        output selected
    );

endinterface

// File: rtl/rom_nibble_responder_store.sv
// Program store: synchronous write port and a registered, enabled read port.
// A same-edge write and read of one address returns the old contents.
module rom_store_256x8
    import rom_nibble_responder_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                  clk_1,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [MEM_ADDR_W-1:0] waddr,
    input  logic [MEM_DATA_W-1:0] wdata,
    input  logic                  re,
    input  logic [MEM_ADDR_W-1:0] raddr,
    output logic [MEM_DATA_W-1:0] rdata
);

    logic [MEM_DATA_W-1:0] mem [DEPTH];

    // No reset on the array so it maps onto block RAM; contents survive reset.
    always_ff @(posedge clk_1) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk_1 or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/rom_nibble_responder.sv
// Memory end of the instruction-fetch cycle: assembles the fetch address from
// the bus, and when the chip nibble matches returns the word low nibble first.
module rom_nibble_responder
    import rom_nibble_responder_pkg::*;
#(
    parameter logic [NIBBLE_W-1:0] CHIP_ID = 4'h0,
    parameter int                  DEPTH   = 256
) (
    input  logic                  clk_1,
    input  logic                  reset_n,
    rom_nibble_responder_if.slave bus,
    input  logic                  prog_we,
    input  logic [MEM_ADDR_W-1:0] prog_addr,
    input  logic [MEM_DATA_W-1:0] prog_data
);

    phase_t                phase_reg;
    phase_t                phase_next;
    logic [MEM_ADDR_W-1:0] addr_reg;
    logic                  selected_reg;
    logic [MEM_DATA_W-1:0] word;
    logic                  read_en;

    assign read_en = (phase_reg == A3);

    rom_store_256x8 #(
        .DEPTH(DEPTH)
    ) u_store (
        .clk_1  (clk_1),
        .reset_n(reset_n),
        .we     (prog_we),
        .waddr  (prog_addr),
        .wdata  (prog_data),
        .re     (read_en),
        .raddr  (addr_reg),
        .rdata  (word)
    );

    always_ff @(posedge clk_1 or negedge reset_n) begin
        if (!reset_n) begin
            phase_reg <= IDLE;
        end else begin
            phase_reg <= phase_next;
        end
    end

    // Next phase plus bus drive. The bus is owned only in M1/M2 of a selected
    // cycle, so a resync (phase back to A1) releases it on that same edge.
    always_comb begin
        phase_next       = phase_reg;
        bus.data_bus_oe  = 1'b0;
        bus.data_bus_out = '0;
        if (!bus.sync_n) begin
            phase_next = A1;
        end else begin
            case (phase_reg)
                IDLE:    phase_next = IDLE;
                A1:      phase_next = A2;
                A2:      phase_next = A3;
                A3:      phase_next = M1;
                M1:      phase_next = M2;
                M2:      phase_next = X1;
                X1:      phase_next = X2;
                X2:      phase_next = X3;
                X3:      phase_next = IDLE;
                default: phase_next = IDLE;
            endcase
        end
        if (selected_reg && (phase_reg == M1 || phase_reg == M2)) begin
            bus.data_bus_oe  = 1'b1;
            bus.data_bus_out = (phase_reg == M1) ? word[3:0] : word[7:4];
        end
    end

    always_ff @(posedge clk_1 or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg <= '0;
        end else if (phase_reg == A1) begin
            addr_reg[3:0] <= bus.data_bus_in;
        end else if (phase_reg == A2) begin
            addr_reg[7:4] <= bus.data_bus_in;
        end
    end

    always_ff @(posedge clk_1 or negedge reset_n) begin
        if (!reset_n) begin
            selected_reg <= 1'b0;
        end else if (!bus.sync_n) begin
            selected_reg <= 1'b0;
        end else if (phase_reg == A3) begin
            selected_reg <= (bus.data_bus_in == CHIP_ID);
        end else if (phase_reg == X3) begin
            selected_reg <= 1'b0;
        end
    end

    assign bus.selected = selected_reg;

endmodule

// File: tb/tb_rom_nibble_responder.sv
// Randomised and directed fetches against a cycles-since-sync reference model.
module tb_rom_nibble_responder;
    import rom_nibble_responder_pkg::*;

    localparam logic [3:0] CHIP = 4'h0;

    logic       clk_1   = 1'b0;
    logic       reset_n = 1'b0;
    logic       prog_we;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;

    rom_nibble_responder_if bus ();

    rom_nibble_responder #(
        .CHIP_ID(CHIP),
        .DEPTH  (256)
    ) dut (
        .clk_1    (clk_1),
        .reset_n  (reset_n),
        .bus      (bus),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data)
    );

    always #5 clk_1 = ~clk_1;

    int checks = 0;
    int errors = 0;

    // Reference: memory image, cycles since the last sync edge (1 = first
    // address cycle, 9 = fetch finished), and the per-fetch decode results.
    logic [7:0] mem_m [256];
    int         cyc_m;
    logic       match_m;
    logic [7:0] addr_m;
    logic [7:0] word_m;
    logic [3:0] obs_out;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic s, input logic [3:0] nib, input logic we,
                        input logic [7:0] wa, input logic [7:0] wd);
        logic       e_oe;
        logic       e_sel;
        logic [3:0] e_out;
        bus.sync_n      = s;
        bus.data_bus_in = nib;
        prog_we         = we;
        prog_addr       = wa;
        prog_data       = wd;
        @(posedge clk_1);
        if (!s) begin
            cyc_m = 1;
        end else begin
            if (cyc_m == 1) addr_m[3:0] = nib;
            if (cyc_m == 2) addr_m[7:4] = nib;
            if (cyc_m == 3) begin
                match_m = (nib == CHIP);
                word_m  = mem_m[addr_m];
            end
            if (cyc_m >= 1 && cyc_m <= 8) cyc_m++;
        end
        if (we) mem_m[wa] = wd;
        #1;
        e_sel = match_m && cyc_m >= 4 && cyc_m <= 8;
        e_oe  = match_m && (cyc_m == 4 || cyc_m == 5);
        e_out = !e_oe ? 4'h0 : (cyc_m == 4) ? word_m[3:0] : word_m[7:4];
        obs_out = bus.data_bus_out;
        check("oe",  8'(bus.data_bus_oe),  8'(e_oe));
        check("bus", 8'(bus.data_bus_out), 8'(e_out));
        check("sel", 8'(bus.selected),     8'(e_sel));
    endtask

    task automatic fetch(input logic [7:0] a, input logic [3:0] chip, input logic chain,
                         input int abort_step, input logic collide, input logic [7:0] cdata,
                         input logic rnd_wr, output logic [3:0] lo, output logic [3:0] hi);
        lo = 4'h0;
        hi = 4'h0;
        for (int i = 0; i < 8; i++) begin
            logic       s;
            logic       we;
            logic [3:0] nib;
            logic [7:0] wa;
            logic [7:0] wd;
            nib = (i == 0) ? a[3:0] : (i == 1) ? a[7:4] : (i == 2) ? chip : 4'($urandom);
            s   = !((i == abort_step) || (i == 7 && chain));
            we  = 1'b0;
            wa  = 8'($urandom);
            wd  = 8'($urandom);
            if (collide && i == 2) begin
                we = 1'b1;
                wa = a;
                wd = cdata;
            end else if (rnd_wr) begin
                we = ($urandom_range(0, 3) == 0);
            end
            step(s, nib, we, wa, wd);
            if (i == 2) lo = obs_out;
            if (i == 3) hi = obs_out;
            if (!s) break;
        end
        $display("fetch addr=%02h chip=%h abort=%0d chain=%b -> lo=%h hi=%h",
                 a, chip, abort_step, chain, lo, hi);
    endtask

    task automatic sync_step();
        step(1'b0, 4'($urandom), 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [3:0] lo;
        logic [3:0] hi;
        logic       chained;
        logic       chain;
        logic [3:0] chip;
        int         abort;

        bus.sync_n      = 1'b1;
        bus.data_bus_in = 4'h0;
        prog_we         = 1'b0;
        prog_addr       = 8'h00;
        prog_data       = 8'h00;
        cyc_m           = 0;
        match_m         = 1'b0;
        addr_m          = 8'h00;
        word_m          = 8'h00;

        repeat (3) @(posedge clk_1);
        #1;
        check("rst_oe",  8'(bus.data_bus_oe),  8'h00);
        check("rst_bus", 8'(bus.data_bus_out), 8'h00);
        check("rst_sel", 8'(bus.selected),     8'h00);
        reset_n = 1'b1;

        for (int i = 0; i < 256; i++) step(1'b1, 4'h0, 1'b1, 8'(i), 8'($urandom));
        step(1'b1, 4'h0, 1'b1, 8'h5A, 8'hC3);
        step(1'b1, 4'h0, 1'b1, 8'h00, 8'h12);
        step(1'b1, 4'h0, 1'b1, 8'hFF, 8'hEF);
        step(1'b1, 4'h0, 1'b1, 8'h10, 8'h7B);

        // Basic selected fetch.
        sync_step();
        fetch(8'h5A, CHIP, 1'b0, 8, 1'b0, 8'h00, 1'b0, lo, hi);
        check("t1_lo", 8'(lo), 8'h03);
        check("t1_hi", 8'(hi), 8'h0C);

        // Chip mismatch: bus stays released.
        sync_step();
        fetch(8'h5A, 4'h2, 1'b0, 8, 1'b0, 8'h00, 1'b0, lo, hi);
        check("t2_lo", 8'(lo), 8'h00);
        check("t2_hi", 8'(hi), 8'h00);

        // Back-to-back fetches with sync in X3.
        sync_step();
        fetch(8'h00, CHIP, 1'b1, 8, 1'b0, 8'h00, 1'b0, lo, hi);
        check("t3a_lo", 8'(lo), 8'h02);
        check("t3a_hi", 8'(hi), 8'h01);
        fetch(8'hFF, CHIP, 1'b0, 8, 1'b0, 8'h00, 1'b0, lo, hi);
        check("t3b_lo", 8'(lo), 8'h0F);
        check("t3b_hi", 8'(hi), 8'h0E);

        // Resync during M1 aborts and restarts at A1.
        sync_step();
        fetch(8'h5A, CHIP, 1'b0, 3, 1'b0, 8'h00, 1'b0, lo, hi);
        check("t4_lo",  8'(lo), 8'h03);
        check("t4_abt", 8'(hi), 8'h00);
        fetch(8'h10, CHIP, 1'b0, 8, 1'b0, 8'h00, 1'b0, lo, hi);
        check("t4b_lo", 8'(lo), 8'h0B);
        check("t4b_hi", 8'(hi), 8'h07);

        // Asynchronous reset during M2.
        sync_step();
        step(1'b1, 4'hA, 1'b0, 8'h00, 8'h00);
        step(1'b1, 4'h5, 1'b0, 8'h00, 8'h00);
        step(1'b1, CHIP, 1'b0, 8'h00, 8'h00);
        step(1'b1, 4'h0, 1'b0, 8'h00, 8'h00);
        check("t5_m2oe", 8'(bus.data_bus_oe), 8'h01);
        #2;
        reset_n = 1'b0;
        #1;
        cyc_m   = 0;
        match_m = 1'b0;
        check("t5_oe",  8'(bus.data_bus_oe),  8'h00);
        check("t5_bus", 8'(bus.data_bus_out), 8'h00);
        check("t5_sel", 8'(bus.selected),     8'h00);
        @(posedge clk_1);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, 4'($urandom), 1'b0, 8'h00, 8'h00);
        sync_step();
        fetch(8'h5A, CHIP, 1'b0, 8, 1'b0, 8'h00, 1'b0, lo, hi);
        check("t5_lo", 8'(lo), 8'h03);
        check("t5_hi", 8'(hi), 8'h0C);

        // Write colliding with the A3 read returns old data, then new data.
        sync_step();
        fetch(8'h5A, CHIP, 1'b0, 8, 1'b1, 8'h99, 1'b0, lo, hi);
        check("t6_lo", 8'(lo), 8'h03);
        check("t6_hi", 8'(hi), 8'h0C);
        sync_step();
        fetch(8'h5A, CHIP, 1'b0, 8, 1'b0, 8'h00, 1'b0, lo, hi);
        check("t6b_lo", 8'(lo), 8'h09);
        check("t6b_hi", 8'(hi), 8'h09);

        // Random fetches, aborts, chaining and background writes.
        chained = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!chained) sync_step();
            chip  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : CHIP;
            abort = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 8;
            chain = 1'($urandom);
            fetch(8'($urandom), chip, chain, abort, 1'b0, 8'h00, 1'b1, lo, hi);
            chained = chain || (abort < 8);
            if (!chained && $urandom_range(0, 1) == 0) step(1'b1, 4'h0, 1'b0, 8'h00, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
